// File: rtl/ifetch_bridge.sv
// ifetch_bridge: instruction-fetch bridge between a core fetch port and a
// single-request memory port, with a one-entry instruction buffer.
// Optional feature: define IFB_TIMEOUT_EN to abandon fetches that wait
// TIMEOUT cycles for an acknowledge (fills a NOP and pulses fetch_err_o).
// Default build (macro undefined) waits indefinitely for mem_ack_i.
//
// Memory handshake: mem_req_o acts as "valid" and mem_ack_i as "ready".
// A request is presented with a fixed mem_addr_o and is held, unchanged,
// until the cycle mem_ack_i is sampled high (or the timeout expires).
// The transfer completes on the edge ending that cycle, and the request is
// never withdrawn early. mem_ack_i outside a request is ignored.
module ifetch_bridge #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
`ifdef IFB_TIMEOUT_EN
  output logic        fetch_err_o,
`endif
  output logic        dbg_state_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_tag_q, buf_tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic        hit;
  logic        miss;
  logic        expire;

`ifdef IFB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // Expiry when the current REQ cycle is the TIMEOUT-th one without ack.
  assign expire = ({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT};
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Buffer lookup: hit/miss and the combinational core-facing outputs.
  always_comb begin
    hit        = rom_ce_i && buf_valid_q && (rom_addr_i == buf_tag_q);
    miss       = rom_ce_i && !hit;
    rom_data_o = hit ? buf_data_q : 32'h0;
    stallreq_o = miss;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start on a miss in IDLE, finish on ack or expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (miss) state_d = S_REQ;
      S_REQ:  if (mem_ack_i || expire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: request registers, buffer fill, wait counter.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
`ifdef IFB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          mem_req_d  = 1'b1;
          mem_addr_d = rom_addr_i;
`ifdef IFB_TIMEOUT_EN
          cnt_d      = 8'h00;
`endif
        end
      end
      S_REQ: begin
        if (mem_ack_i) begin
          // Ack wins even in the expiry cycle.
          buf_data_d  = mem_data_i;
          buf_tag_d   = mem_addr_q;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
        end else if (expire) begin
          // Abandoned fetch: buffer a NOP under the requested tag.
          buf_data_d  = 32'h0;
          buf_tag_d   = mem_addr_q;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
`ifdef IFB_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end else begin
`ifdef IFB_TIMEOUT_EN
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      buf_data_q  <= 32'h0;
      buf_tag_q   <= 32'h0;
      buf_valid_q <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      buf_data_q  <= buf_data_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
    end
  end

`ifdef IFB_TIMEOUT_EN
  // Wait counter and error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err_o = err_q;
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign dbg_state_o = (state_q == S_REQ);

endmodule

// File: tb/tb_ifetch_bridge.sv
// Testbench for ifetch_bridge: directed fetch scenarios, a transaction-level
// model of the bridge checked every cycle, and literal spot checks.
module tb_ifetch_bridge;

  localparam logic [7:0] TMO = 8'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stallreq;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        dbg_state;
`ifdef IFB_TIMEOUT_EN
  logic        fetch_err;
`endif

  always #5 clk = ~clk;

  ifetch_bridge #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data),
    .stallreq_o (stallreq),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_ack_i  (mem_ack),
    .mem_data_i (mem_data),
`ifdef IFB_TIMEOUT_EN
    .fetch_err_o(fetch_err),
`endif
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a fetch is pending or not; each pending cycle counts
  // toward the timeout; completion fills the one-entry buffer.
  logic        m_pend;
  logic [31:0] m_addr;
  logic        m_bv;
  logic [31:0] m_tag;
  logic [31:0] m_data;
  int          m_reqcyc;
  logic        m_err;
  logic [31:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend   <= 1'b0;
      m_addr   <= 32'h0;
      m_bv     <= 1'b0;
      m_tag    <= 32'h0;
      m_data   <= 32'h0;
      m_reqcyc <= 0;
      m_err    <= 1'b0;
      exp_q.delete();
    end else begin
      m_err <= 1'b0;
      if (m_pend) begin
        m_reqcyc <= m_reqcyc + 1;
        if (mem_ack) begin
          m_bv   <= 1'b1;
          m_tag  <= m_addr;
          m_data <= mem_data;
          m_pend <= 1'b0;
        end
`ifdef IFB_TIMEOUT_EN
        else if (m_reqcyc + 1 >= int'(TMO)) begin
          m_bv   <= 1'b1;
          m_tag  <= m_addr;
          m_data <= 32'h0;
          m_pend <= 1'b0;
          m_err  <= 1'b1;
        end
`endif
      end else if (rom_ce && !(m_bv && rom_addr == m_tag)) begin
        m_pend   <= 1'b1;
        m_addr   <= rom_addr;
        m_reqcyc <= 0;
        exp_q.push_back(rom_addr);
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic        prev_req = 1'b0;
  logic        e_hit;
  logic [31:0] got_addr;

  always @(negedge clk) begin
    e_hit = rom_ce && m_bv && (rom_addr == m_tag);
    chk("mdl_rom_data", rom_data, e_hit ? m_data : 32'h0);
    chk("mdl_stall", {31'h0, stallreq}, {31'h0, rom_ce && !e_hit});
    chk("mdl_mem_req", {31'h0, mem_req}, {31'h0, m_pend});
    chk("mdl_mem_addr", mem_addr, m_addr);
    chk("mdl_dbg_state", {31'h0, dbg_state}, {31'h0, m_pend});
`ifdef IFB_TIMEOUT_EN
    chk("mdl_fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
`endif
    // Each rising request must match the next address the model issued.
    if (mem_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_req", mem_addr, 32'hFFFF_FFFF);
      end else begin
        got_addr = exp_q.pop_front();
        chk("sb_req_addr", mem_addr, got_addr);
      end
    end
    prev_req = mem_req;
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle, apply inputs just after the edge, sample at negedge.
  task automatic sas(input logic ce, input logic [31:0] addr,
                     input logic ack, input logic [31:0] data);
    @(posedge clk);
    #1;
    rom_ce   = ce;
    rom_addr = addr;
    mem_ack  = ack;
    mem_data = data;
    @(negedge clk);
  endtask

  logic [31:0] t_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [31:0] t_data [4] = '{32'h1000_0100, 32'h2000_0104, 32'h3000_0108, 32'h4000_010C};
  int          t_dly  [4] = '{0, 2, 1, 3};

  // ---------------- directed stimulus ----------------
  initial begin
    rst      = 1'b0;
    rom_ce   = 1'b0;
    rom_addr = 32'h0;
    mem_ack  = 1'b0;
    mem_data = 32'h0;

    // Reset state
    sas(1'b1, 32'h0, 1'b0, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rom_data", rom_data, 32'h0);
    @(posedge clk); #1; rom_ce = 1'b0; rst = 1'b1;

    // Miss with ack in the first request cycle
    sas(1'b1, 32'h0, 1'b0, 32'h0);
    chk("t1_c0_stall", {31'h0, stallreq}, 32'h1);
    chk("t1_c0_req", {31'h0, mem_req}, 32'h0);
    sas(1'b1, 32'h0, 1'b1, 32'h3401_1100);
    chk("t1_c1_req", {31'h0, mem_req}, 32'h1);
    chk("t1_c1_stall", {31'h0, stallreq}, 32'h1);
    chk("t1_c1_addr", mem_addr, 32'h0);
    sas(1'b1, 32'h0, 1'b0, 32'h0);
    chk("t1_c2_data", rom_data, 32'h3401_1100);
    chk("t1_c2_stall", {31'h0, stallreq}, 32'h0);
    chk("t1_c2_req", {31'h0, mem_req}, 32'h0);

    // Held hit
    for (int i = 0; i < 3; i++) begin
      sas(1'b1, 32'h0, 1'b0, 32'h0);
      chk("held_data", rom_data, 32'h3401_1100);
      chk("held_stall", {31'h0, stallreq}, 32'h0);
      chk("held_req", {31'h0, mem_req}, 32'h0);
    end

    // Address change mid-fetch
    sas(1'b1, 32'h4, 1'b0, 32'h0);
    chk("t3_miss_stall", {31'h0, stallreq}, 32'h1);
    sas(1'b1, 32'h8, 1'b0, 32'h0);
    chk("t3_req_addr", mem_addr, 32'h4);
    sas(1'b1, 32'h8, 1'b0, 32'h0);
    sas(1'b1, 32'h8, 1'b0, 32'h0);
    sas(1'b1, 32'h8, 1'b1, 32'hAAAA_0004);
    chk("t3_ack_req", {31'h0, mem_req}, 32'h1);
    chk("t3_ack_addr", mem_addr, 32'h4);
    sas(1'b1, 32'h8, 1'b0, 32'h0);
    chk("t3_idle_req", {31'h0, mem_req}, 32'h0);
    chk("t3_idle_stall", {31'h0, stallreq}, 32'h1);
    sas(1'b1, 32'h8, 1'b1, 32'hBBBB_0008);
    chk("t3_new_req", {31'h0, mem_req}, 32'h1);
    chk("t3_new_addr", mem_addr, 32'h8);
    sas(1'b1, 32'h8, 1'b0, 32'h0);
    chk("t3_hit8", rom_data, 32'hBBBB_0008);

    // Enable falls during the fetch; fill still lands
    sas(1'b1, 32'h10, 1'b0, 32'h0);
    sas(1'b0, 32'h10, 1'b0, 32'h0);
    chk("t4_ce0_stall", {31'h0, stallreq}, 32'h0);
    chk("t4_ce0_req", {31'h0, mem_req}, 32'h1);
    sas(1'b0, 32'h10, 1'b1, 32'hCAFE_0010);
    sas(1'b1, 32'h10, 1'b0, 32'h0);
    chk("t4_hit", rom_data, 32'hCAFE_0010);
    chk("t4_hit_stall", {31'h0, stallreq}, 32'h0);

    // Ack in IDLE is ignored
    sas(1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
    sas(1'b1, 32'h10, 1'b1, 32'hDEAD_0000);
    sas(1'b1, 32'h10, 1'b0, 32'h0);
    chk("t5_ign_data", rom_data, 32'hCAFE_0010);
    chk("t5_ign_req", {31'h0, mem_req}, 32'h0);

    // Asynchronous reset mid-fetch
    sas(1'b1, 32'h20, 1'b0, 32'h0);
    sas(1'b0, 32'h20, 1'b0, 32'h0);
    chk("t6_pre_req", {31'h0, mem_req}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("t6_async_req", {31'h0, mem_req}, 32'h0);
    chk("t6_async_addr", mem_addr, 32'h0);
    chk("t6_async_stall", {31'h0, stallreq}, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    sas(1'b1, 32'h10, 1'b0, 32'h0);
    chk("t6_bufinv_stall", {31'h0, stallreq}, 32'h1);
    chk("t6_bufinv_data", rom_data, 32'h0);
    sas(1'b1, 32'h10, 1'b1, 32'h1111_0010);
    chk("t6_first_req", {31'h0, mem_req}, 32'h1);
    sas(1'b1, 32'h10, 1'b0, 32'h0);
    chk("t6_refill", rom_data, 32'h1111_0010);

    // Table of fetches with assorted ack delays
    for (int k = 0; k < 4; k++) begin
      sas(1'b1, t_addr[k], 1'b0, 32'h0);
      for (int d = 0; d <= t_dly[k]; d++) begin
        sas(1'b1, t_addr[k], (d == t_dly[k]), t_data[k]);
      end
      sas(1'b1, t_addr[k], 1'b0, 32'h0);
      chk("tbl_data", rom_data, t_data[k]);
      chk("tbl_stall", {31'h0, stallreq}, 32'h0);
    end

`ifdef IFB_TIMEOUT_EN
    // Timeout with no ack
    sas(1'b1, 32'h40, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      sas(1'b1, 32'h40, 1'b0, 32'h0);
      chk("to_req_hi", {31'h0, mem_req}, 32'h1);
      chk("to_err_lo", {31'h0, fetch_err}, 32'h0);
    end
    sas(1'b1, 32'h40, 1'b0, 32'h0);
    chk("to_req_drop", {31'h0, mem_req}, 32'h0);
    chk("to_err_pulse", {31'h0, fetch_err}, 32'h1);
    chk("to_nop", rom_data, 32'h0);
    chk("to_stall", {31'h0, stallreq}, 32'h0);
    sas(1'b1, 32'h40, 1'b0, 32'h0);
    chk("to_err_once", {31'h0, fetch_err}, 32'h0);

    // Ack in the expiry cycle wins
    sas(1'b1, 32'h44, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) sas(1'b1, 32'h44, 1'b0, 32'h0);
    sas(1'b1, 32'h44, 1'b1, 32'h1234_5678);
    chk("exp_ack_req", {31'h0, mem_req}, 32'h1);
    sas(1'b1, 32'h44, 1'b0, 32'h0);
    chk("exp_ack_noerr", {31'h0, fetch_err}, 32'h0);
    chk("exp_ack_data", rom_data, 32'h1234_5678);
    chk("exp_ack_stall", {31'h0, stallreq}, 32'h0);
`else
    // Without the timeout the request waits indefinitely
    sas(1'b1, 32'h40, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      sas(1'b1, 32'h40, 1'b0, 32'h0);
      chk("wait_req_hi", {31'h0, mem_req}, 32'h1);
    end
    sas(1'b1, 32'h40, 1'b1, 32'h0BAD_0040);
    sas(1'b1, 32'h40, 1'b0, 32'h0);
    chk("wait_data", rom_data, 32'h0BAD_0040);
    chk("wait_stall", {31'h0, stallreq}, 32'h0);
`endif

    sas(1'b0, 32'h0, 1'b0, 32'h0);
    sas(1'b0, 32'h0, 1'b0, 32'h0);
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 Parameter TIMEOUT, default 8'd255, SHALL set the cycle count in REQ state after which a fetch is abandoned.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 rom_ce_i  input  1  core fetch enable.
REQ-005 rom_addr_i  input  32  core fetch address (PC).
REQ-006 rom_data_o  output  32  instruction returned to the core.
REQ-007 stallreq_o  output  1  request for the core to hold its PC while the fetch is pending.
REQ-008 mem_req_o  output  1  memory-side request, registered.
REQ-009 mem_addr_o  output  32  memory-side address, registered.
REQ-010 mem_ack_i  input  1  memory-side acknowledge; data is valid in the same cycle.
REQ-011 mem_data_i  input  32  memory-side read data.
REQ-012 fetch_err_o  output  1  one-cycle pulse when a fetch times out; present only with IFB_TIMEOUT_EN.

Function
REQ-013 The bridge SHALL hold a one-entry buffer: buf_data[31:0], buf_tag[31:0] and buf_valid.
REQ-014 A hit SHALL be rom_ce_i=1, buf_valid=1 and rom_addr_i==buf_tag; a miss SHALL be rom_ce_i=1 with no hit.
REQ-015 rom_data_o SHALL be buf_data on a hit and 32'h0 otherwise; it is combinational.
REQ-016 stallreq_o SHALL be 1 on a miss and 0 on a hit or when rom_ce_i=0; it is combinational.
REQ-017 The FSM SHALL have exactly two states, IDLE and REQ.
REQ-018 In IDLE on a miss, the next edge SHALL enter REQ, set mem_req_o=1, load mem_addr_o=rom_addr_i and clear the wait counter.
REQ-019 In REQ, mem_req_o and mem_addr_o SHALL stay constant until the transaction ends; the handshake never withdraws a request early.
REQ-020 In REQ with mem_ack_i=1, the edge SHALL load buf_data=mem_data_i, buf_tag=mem_addr_o and buf_valid=1, clear mem_req_o and return to IDLE.
REQ-021 Latency SHALL be as follows: a miss in cycle 0 gives mem_req_o in cycle 1. An ack in cycle k (k>=1) gives a hit, with stallreq_o=0, in cycle k+1.
REQ-022 An ack in the cycle mem_req_o first rises SHALL be legal, giving a 2-cycle stall.
REQ-023 If rom_addr_i changes during REQ, the in-flight fetch SHALL complete under the old tag; the resulting miss then starts a new fetch from IDLE.
REQ-024 If rom_ce_i falls during REQ, the in-flight fetch SHALL complete and fill the buffer; stallreq_o SHALL be 0 while rom_ce_i=0.
REQ-025 mem_ack_i SHALL be ignored in IDLE.
REQ-026 A transaction SHALL never start in the same cycle another completes; at least one IDLE cycle separates transactions.
REQ-027 The wait counter SHALL be 8 bits, increment once per REQ cycle without ack, and saturate at 8'hFF.

Reset
REQ-028 While rst=0, the block SHALL immediately force state=IDLE, mem_req_o=0, mem_addr_o=0, buf_valid=0, buf_data=0, buf_tag=0, counter=0 and fetch_err_o=0.
REQ-029 Asserting rst during REQ SHALL abort the transaction, with mem_req_o dropping without waiting for clk.
REQ-030 The first miss after rst releases SHALL issue a request on the next edge.

Configuration
REQ-031 With macro IFB_TIMEOUT_EN defined, REQ lasting TIMEOUT cycles without ack SHALL end at the next edge. That edge loads buf_data=32'h0 (NOP), buf_tag=mem_addr_o and buf_valid=1, drops mem_req_o, pulses fetch_err_o for one cycle and returns to IDLE.
REQ-032 With IFB_TIMEOUT_EN defined, an ack in the expiry cycle SHALL take priority: the data is captured and there is no error pulse.
REQ-033 Without IFB_TIMEOUT_EN, the bridge SHALL wait indefinitely for mem_ack_i, fetch_err_o SHALL be absent and the counter logic SHALL not be built.

Verification
REQ-034 Miss with same-cycle ack: ce=1, addr=0x0000_0000; ack in cycle 1 with data 0x3401_1100 -> mem_req_o high for cycle 1, stallreq_o 1 in cycles 0-1, rom_data_o=0x3401_1100 and stall 0 in cycle 2.
REQ-035 Held hit: addr held at 0x0 after the fill -> no further mem_req_o, rom_data_o stable, stallreq_o=0.
REQ-036 Address change mid-fetch: addr 0x4 -> 0x8 during REQ, ack 3 cycles later -> tag 0x4 buffered, then a new request for 0x8 after one IDLE cycle.
REQ-037 Reset mid-fetch: rst=0 asynchronously during REQ -> mem_req_o=0 before the next edge, buf_valid=0, stallreq_o=0 while ce=0.
REQ-038 Timeout (IFB_TIMEOUT_EN, TIMEOUT=4): no ack -> mem_req_o high for 4 cycles then low, fetch_err_o pulses once, rom_data_o=0x0000_0000 with stall 0.
REQ-039 Ack on expiry (IFB_TIMEOUT_EN, TIMEOUT=4): ack in the 4th REQ cycle -> data captured, no fetch_err_o pulse.
